// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the two-port RAM arbiter.
//   state_e        - sequencer states IDLE / ACCESS / RESP
//   RAM_ADDR_W     - default address width (RAM depth 2^RAM_ADDR_W)
//   RAM_DATA_W     - default word width
//   PORT_A/PORT_B  - port identifiers used for grants and the last-grant pointer
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int RAM_ADDR_W = 4;
  localparam int RAM_DATA_W = 8;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner selection between ports A and B.
// Build option: RAM_ARB_FIXED_PRIO_EN selects fixed priority (A always wins,
// no pointer input); otherwise round-robin using the last-grant pointer.
// Ports:
//   a_req, b_req  - pending requests
//   last_port     - port granted last (round-robin build only)
//   gnt_vld       - some port is requesting
//   gnt_port      - winning port id (PORT_A / PORT_B)
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
`ifndef RAM_ARB_FIXED_PRIO_EN
  input  logic last_port,
`endif
  output logic gnt_vld,
  output logic gnt_port
);

  always_comb begin
    gnt_vld  = a_req | b_req;
    gnt_port = PORT_A;
`ifdef RAM_ARB_FIXED_PRIO_EN
    if (!a_req && b_req) gnt_port = PORT_B;
`else
    if (a_req && b_req) begin
      // Contention: the port that did not win last time goes first.
      gnt_port = (last_port == PORT_A) ? PORT_B : PORT_A;
    end else if (b_req) begin
      gnt_port = PORT_B;
    end
`endif
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter and sequencer for a 2^ADDR_W x DATA_W RAM.
// Serialises read/write requests from ports A and B (req/ack handshake),
// drives registered, glitch-free RAM strobes and returns read data per port.
// Build option: RAM_ARB_FIXED_PRIO_EN = fixed priority (A beats B, no pointer);
// default is round-robin.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   a_/b_req, we, addr, wdata     - per-port request, held until ack
//   a_/b_ack                      - one-cycle completion pulse
//   a_/b_rdata                    - last read data for that port
//   ram_cs, ram_oa, ram_wa        - RAM chip select / output enable / write enable
//   ram_addr, ram_wdata           - RAM address and write data
//   ram_rdata                     - RAM read data (combinational from RAM)
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_cs,
  output logic              ram_oa,
  output logic              ram_wa,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_e state_q, state_d;
  logic   gnt_vld;
  logic   gnt_port;
  logic   cur_port_q;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifndef RAM_ARB_FIXED_PRIO_EN
  logic last_port_q;
`endif

  ram_arb_pick u_pick (
    .a_req     (a_req),
    .b_req     (b_req),
`ifndef RAM_ARB_FIXED_PRIO_EN
    .last_port (last_port_q),
`endif
    .gnt_vld   (gnt_vld),
    .gnt_port  (gnt_port)
  );

  assign sel_we    = (gnt_port == PORT_B) ? b_we    : a_we;
  assign sel_addr  = (gnt_port == PORT_B) ? b_addr  : a_addr;
  assign sel_wdata = (gnt_port == PORT_B) ? b_wdata : a_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and acks are registered from the transition into the next state,
  // so each output is a flop and never glitches. Strobes default low every
  // cycle; only the IDLE->ACCESS transition raises them for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_cs      <= 1'b0;
      ram_oa      <= 1'b0;
      ram_wa      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
      cur_port_q  <= PORT_A;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_port_q <= PORT_B;
`endif
    end else begin
      ram_cs <= 1'b0;
      ram_oa <= 1'b0;
      ram_wa <= 1'b0;
      a_ack  <= 1'b0;
      b_ack  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            cur_port_q  <= gnt_port;
            ram_cs      <= 1'b1;
            ram_wa      <= sel_we;
            ram_oa      <= ~sel_we;
            ram_addr    <= sel_addr;
            ram_wdata   <= sel_wdata;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_port_q <= gnt_port;
`endif
          end
        end
        ACCESS: begin
          // ram_oa marks this access as a read; capture on the closing edge.
          if (ram_oa) begin
            if (cur_port_q == PORT_A) a_rdata <= ram_rdata;
            else                      b_rdata <= ram_rdata;
          end
          a_ack <= (cur_port_q == PORT_A);
          b_ack <= (cur_port_q == PORT_B);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer for the 16-word × 8-bit RAM. It accepts independent read/write requests from ports A and B over a req/ack handshake, serialises them with round-robin priority, and drives the RAM chip-select, output-enable, write-enable and address strobes. It sits between the two bus masters and the RAM. Tri-state bus glue for the RAM stays in the top level.

## Interface
- ADDR_W, 4, address width (RAM depth 2^ADDR_W)
- DATA_W, 8, word width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- a_req / b_req  in  1  request, held high until ack
- a_we / b_we  in  1  1 = write, 0 = read; stable while req high
- a_addr / b_addr  in  ADDR_W  word address; stable while req high
- a_wdata / b_wdata  in  DATA_W  write data; stable while req high
- a_ack / b_ack  out  1  one-cycle completion pulse
- a_rdata / b_rdata  out  DATA_W  read data, valid from ack, held until that port's next read completes
- ram_cs, ram_oa, ram_wa  out  1  RAM chip select, output enable, write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  data to RAM write path
- ram_rdata  in  DATA_W  data from RAM read path (combinational from RAM)

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req is high, latch the winner's we, addr, wdata and port id, then go to ACCESS. Otherwise stay in IDLE.
- ACCESS, exactly one cycle:
  - Write: ram_cs=1, ram_wa=1, ram_oa=0, ram_wdata=latched data. The RAM captures on the closing edge.
  - Read: ram_cs=1, ram_oa=1, ram_wa=0. ram_rdata is sampled on the closing edge into the winner's rdata register.
  - Next state is RESP.
- RESP: the winner's ack=1 for one cycle. All ram_* strobes are 0. Next state is IDLE.
- Arbitration:
  - A single requester always wins.
  - On a simultaneous request, the port not granted last wins.
  - The last-grant pointer updates on every grant. After reset the pointer favours A.
- A req that is still high in the IDLE cycle after RESP is a new request.
- Dropping req before ack is a protocol violation. The transaction still completes and acks.
- ram_cs, ram_oa, ram_wa, ram_addr and ram_wdata are registered (decoded from state flops), so they are glitch-free. ram_wa and ram_oa are never both 1.

## Timing
- Request sampled at edge N (IDLE) → ACCESS during cycle N+1 → ack high during cycle N+2 → IDLE at N+3.
- Fixed 3-cycle latency. Peak throughput is one access per 3 cycles.
- A losing requester waits one full transaction. Worst-case latency is 6 cycles.
- Reset values: all ack=0, ram_cs=ram_oa=ram_wa=0, ram_addr=0, ram_wdata=0, a_rdata=b_rdata=0, state IDLE, pointer favours A.
- Reset mid-ACCESS or mid-RESP:
  - All outputs return to reset values immediately (asynchronous).
  - The transaction is dropped and no ack is issued.
  - A write interrupted in ACCESS is not guaranteed to land.

## Configuration
- RAM_ARB_FIXED_PRIO_EN defined: fixed priority, A always beats B. The pointer is not implemented. B can starve.
- Undefined (default): round-robin as described above.

## Structure
- Package ram_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - default ADDR_W/DATA_W localparams;
  - port-id constants PORT_A=0, PORT_B=1.
- One sub-module, ram_arb_pick: combinational winner selection from a_req, b_req and the pointer. The macro selects its fixed-priority variant.

## Test plan
- After reset, A writes 8'h5A to addr 3 → a_ack in cycle N+2. Then A reads addr 3 → a_rdata=8'h5A at ack. ram_wa=1 only in the write ACCESS cycle.
- A and B request simultaneously: A writes 8'h11 to addr 0, B writes 8'h22 to addr 0. A wins (reset pointer), then B. A final read of addr 0 returns 8'h22.
- Both ports hold req continuously for 8 transactions → grants alternate A,B,A,B…
  - With RAM_ARB_FIXED_PRIO_EN, B is never acked while A holds req.
- B reads addr 15 after A writes 8'hFF there → b_rdata=8'hFF, and a_rdata is unchanged.
- rst asserted during the ACCESS of B's write to addr 7 → all strobes and acks go 0 in the same cycle, no b_ack. After reset, state is IDLE and the pointer favours A.
